input_channel_buffer: RTL and testbench

Per-input-port flit buffer and route-request generator for the AXI router crossbar. It accepts flits from the upstream link and stores them in a first-word-fall-through FIFO. It decodes the destination of each packet's head flit into a one-hot request toward the output-port arbiters, and pops flits when the granted output switch reads them. It is the supplier of the `rok` signals and the consumer of the read strobes that the output-side valid and grant logic exchange with each input channel.

---
 rtl/router_pkg.sv | 19 +
 rtl/sync_fifo_fwft.sv | 53 +++++
 rtl/input_channel_buffer.sv | 100 ++++++++++
 tb/tb_input_channel_buffer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared router definitions: the channel state encoding,
// the flit layout and where the destination sits in a head flit.
package router_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ROUTED,
    DROP
  } state_t;

  localparam int FLIT_DATA_W = 32;
  localparam int DEST_LSB = 0;

  typedef struct packed {
    logic                   last;
    logic [FLIT_DATA_W-1:0] payload;
  } flit_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO: the oldest entry is always on head,
// so a read is just a pop with no extra latency.
module sync_fifo_fwft #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    count;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rptr];

  // Storage is not reset; empty masks stale contents.
  always_ff @(posedge clk) begin
    if (push)
      mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push)
        wptr <= wptr + AW'(1);
      if (pop)
        rptr <= rptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/input_channel_buffer.sv
// Input channel: buffers upstream flits and turns each packet's head
// destination into a one-hot request toward the output arbiters.
module input_channel_buffer
  import router_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int DEPTH           = 4,
  parameter int NUMBER_CHANNELS = 5,
  parameter int DEST_BITS       = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_WIDTH-1:0]      din,
  input  logic                       din_last,
  input  logic                       wr,
  output logic                       wok,
  output logic [DATA_WIDTH-1:0]      dout,
  output logic                       dout_last,
  output logic                       rok,
  output logic [NUMBER_CHANNELS-1:0] req,
  input  logic [NUMBER_CHANNELS-1:0] rd
);

  localparam int FW = DATA_WIDTH + 1;

  logic [FW-1:0]        head;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  logic [DEST_BITS-1:0] dest;
  logic                 dest_ok;
  state_t               state;

  assign wok  = !rst && !full;
  assign push = wr && wok;
  assign rok  = !empty;

  assign {dout_last, dout} = head;

  assign dest    = dout[DEST_LSB +: DEST_BITS];
  assign dest_ok = int'(dest) < NUMBER_CHANNELS;

  always_comb begin
    pop = 1'b0;
    unique case (state)
      ROUTED:  pop = rok && |(rd & req);
      DROP:    pop = rok;
      default: pop = 1'b0;
    endcase
  end

  sync_fifo_fwft #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({din_last, din}),
    .pop   (pop),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  // Unroutable destinations are drained so they cannot block the port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      req   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (rok && dest_ok) begin
            state <= ROUTED;
            req   <= NUMBER_CHANNELS'(1) << dest;
          end else if (rok) begin
            state <= DROP;
          end
        end
        ROUTED: begin
          if (pop && dout_last) begin
            state <= IDLE;
            req   <= '0;
          end
        end
        DROP: begin
          if (pop && dout_last)
            state <= IDLE;
        end
        default: begin
          state <= IDLE;
          req   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_input_channel_buffer.sv
// Directed vectors and multi-cycle sequences for the input channel.
module tb_input_channel_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] din = '0;
  logic        din_last = 1'b0;
  logic        wr = 1'b0;
  logic        wok;
  logic [31:0] dout;
  logic        dout_last;
  logic        rok;
  logic [4:0]  req;
  logic [4:0]  rd = '0;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  input_channel_buffer #(
    .DATA_WIDTH      (32),
    .DEPTH           (4),
    .NUMBER_CHANNELS (5),
    .DEST_BITS       (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_last  (din_last),
    .wr        (wr),
    .wok       (wok),
    .dout      (dout),
    .dout_last (dout_last),
    .rok       (rok),
    .req       (req),
    .rd        (rd)
  );

  typedef struct {
    logic        rst;
    logic        wr;
    logic [31:0] din;
    logic        last;
    logic [4:0]  rd;
    logic        rok;
    logic [4:0]  req;
    logic        wok;
    logic        chk_d;
    logic [31:0] dout;
    logic        dlast;
  } vec_t;

  vec_t vt [15];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", name, act, exp);
    else
      n_pass++;
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic w, input logic [31:0] d,
                       input logic l, input logic [4:0] r);
    wr = w;
    din = d;
    din_last = l;
    rd = r;
  endtask

  int q_exp [$];
  int widx;
  int npkt;
  int zrun;
  int ncyc;
  logic [4:0] prev_req;
  logic [4:0] exp_req;
  int fl;

  initial begin
    vt[0]  = '{1,0,32'h0,  0,5'h00, 0,5'h00,0, 0,32'h0,  0};
    vt[1]  = '{0,1,32'h2,  1,5'h00, 0,5'h00,1, 0,32'h0,  0};
    vt[2]  = '{0,0,32'h0,  0,5'h00, 1,5'h00,1, 1,32'h2,  1};
    vt[3]  = '{0,0,32'h0,  0,5'h04, 1,5'h04,1, 1,32'h2,  1};
    vt[4]  = '{0,0,32'h0,  0,5'h00, 0,5'h00,1, 0,32'h0,  0};
    vt[5]  = '{0,1,32'h100,0,5'h00, 0,5'h00,1, 0,32'h0,  0};
    vt[6]  = '{0,1,32'h200,0,5'h00, 1,5'h00,1, 1,32'h100,0};
    vt[7]  = '{0,1,32'h300,0,5'h00, 1,5'h01,1, 1,32'h100,0};
    vt[8]  = '{0,1,32'h400,1,5'h00, 1,5'h01,1, 1,32'h100,0};
    vt[9]  = '{0,1,32'h500,0,5'h00, 1,5'h01,0, 1,32'h100,0};
    vt[10] = '{0,0,32'h0,  0,5'h01, 1,5'h01,0, 1,32'h100,0};
    vt[11] = '{0,0,32'h0,  0,5'h01, 1,5'h01,1, 1,32'h200,0};
    vt[12] = '{0,0,32'h0,  0,5'h01, 1,5'h01,1, 1,32'h300,0};
    vt[13] = '{0,0,32'h0,  0,5'h01, 1,5'h01,1, 1,32'h400,1};
    vt[14] = '{0,0,32'h0,  0,5'h00, 0,5'h00,1, 0,32'h0,  0};

    @(negedge clk);
    cyc();

    for (int i = 0; i < 15; i++) begin
      rst = vt[i].rst;
      drive(vt[i].wr, vt[i].din, vt[i].last, vt[i].rd);
      #1;
      chk($sformatf("v%0d_rok", i), 32'(rok), 32'(vt[i].rok));
      chk($sformatf("v%0d_req", i), 32'(req), 32'(vt[i].req));
      chk($sformatf("v%0d_wok", i), 32'(wok), 32'(vt[i].wok));
      if (vt[i].chk_d) begin
        chk($sformatf("v%0d_dout", i), dout, vt[i].dout);
        chk($sformatf("v%0d_last", i), 32'(dout_last),
            32'(vt[i].dlast));
      end
      cyc();
    end

    // Strobes outside req are ignored; several strobes pop once.
    drive(1, 32'h10, 0, 5'h00); cyc();
    drive(1, 32'h11, 0, 5'h00); cyc();
    drive(1, 32'h12, 1, 5'h00); cyc();
    drive(0, 32'h0, 0, 5'h00);
    chk("rs_req", 32'(req), 32'h01);
    rd = 5'b00010; cyc();
    chk("rs_nopop", dout, 32'h10);
    rd = 5'b00011; cyc();
    chk("rs_onepop", dout, 32'h11);
    cyc();
    chk("rs_tail", dout, 32'h12);
    cyc();
    rd = 5'h00;
    chk("rs_empty", 32'(rok), 32'h0);
    cyc();

    // Unroutable head is drained one flit per cycle.
    drive(1, 32'h6, 0, 5'h00);
    chk("dr_req0", 32'(req), 32'h0); cyc();
    drive(1, 32'h7, 0, 5'h00);
    chk("dr_req1", 32'(req), 32'h0); cyc();
    drive(1, 32'h8, 1, 5'h00);
    chk("dr_d2", dout, 32'h6);
    chk("dr_req2", 32'(req), 32'h0); cyc();
    drive(1, 32'h1, 1, 5'h00);
    chk("dr_d3", dout, 32'h7);
    chk("dr_req3", 32'(req), 32'h0); cyc();
    drive(0, 32'h0, 0, 5'h00);
    chk("dr_d4", dout, 32'h8);
    chk("dr_req4", 32'(req), 32'h0); cyc();
    chk("dr_d5", dout, 32'h1);
    chk("dr_req5", 32'(req), 32'h0); cyc();
    chk("dr_req6", 32'(req), 32'h02);
    rd = 5'b00010; cyc();
    rd = 5'h00;
    chk("dr_empty", 32'(rok), 32'h0);
    chk("dr_idle", 32'(req), 32'h0);
    cyc();

    // Eight 2-flit packets streamed with every strobe held.
    for (int p = 0; p < 8; p++) begin
      q_exp.push_back((p << 8) | ((p % 2 == 0) ? 3 : 4));
      q_exp.push_back((p << 8) | 32'h80);
    end
    widx = 0; npkt = 0; zrun = 0; ncyc = 0; fl = 0;
    prev_req = '0;
    rd = 5'b11111;
    while (fl < 16 && ncyc < 200) begin
      if (widx < 16 && wok) begin
        wr = 1'b1;
        din = ((widx / 2) << 8) |
              ((widx % 2 == 1) ? 32'h80 :
               (((widx / 2) % 2 == 0) ? 32'h3 : 32'h4));
        din_last = (widx % 2 == 1);
        widx++;
      end else begin
        wr = 1'b0;
      end
      if (req != 0 && prev_req == 0) begin
        exp_req = (npkt % 2 == 0) ? 5'b01000 : 5'b10000;
        chk($sformatf("bb_req%0d", npkt), 32'(req), 32'(exp_req));
        if (npkt > 0)
          chk($sformatf("bb_gap%0d", npkt), zrun, 1);
        npkt++;
      end
      zrun = (req == 0) ? zrun + 1 : 0;
      if (rok && req != 0) begin
        chk($sformatf("bb_d%0d", fl), dout, q_exp[fl]);
        fl++;
      end
      prev_req = req;
      cyc();
      ncyc++;
    end
    wr = 1'b0;
    rd = 5'h00;
    chk("bb_all_popped", fl, 16);
    chk("bb_empty", 32'(rok), 32'h0);
    cyc();

    // Reset with part of a routed packet buffered.
    drive(1, 32'h22, 0, 5'h00); cyc();
    drive(1, 32'h23, 0, 5'h00); cyc();
    drive(1, 32'h24, 0, 5'h00); cyc();
    drive(0, 32'h0, 0, 5'h00);
    chk("mr_req", 32'(req), 32'h04);
    rst = 1'b1;
    #1;
    chk("mr_wok_rst", 32'(wok), 32'h0);
    cyc();
    chk("mr_rok_rst", 32'(rok), 32'h0);
    chk("mr_req_rst", 32'(req), 32'h0);
    chk("mr_wok_rst2", 32'(wok), 32'h0);
    rst = 1'b0;
    #1;
    chk("mr_wok_after", 32'(wok), 32'h1);
    chk("mr_rok_after", 32'(rok), 32'h0);
    drive(1, 32'h54, 1, 5'h00); cyc();
    drive(0, 32'h0, 0, 5'h00); cyc();
    chk("mr_new_req", 32'(req), 32'h10);
    chk("mr_new_dout", dout, 32'h54);
    rd = 5'b10000; cyc();
    rd = 5'h00;
    chk("mr_done", 32'(rok), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
